morph_program_sequencer: RTL and testbench

Sequences a chain of morphological steps over one binary image. Each step is a 12-bit gene: a 9-bit structuring element plus a 3-bit op code. Per step, the block drives the combinational morphologic unit (instantiated externally, shared through ports), registers its result and feeds it back as the next step's input. It sits between the genetic-program store/evaluator and the morphologic unit, and executes a stored program of up to MaxSteps genes per image.

---
 rtl/morph_program_sequencer.sv | 159 +++++++++++++++
 tb/tb_morph_program_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/morph_program_sequencer.sv
// Runs a stored chain of morphological genes over one binary image, feeding each
// step's result from the external morphologic unit back as the next step's input.
module morph_program_sequencer #(
    parameter  int unsigned ImageWidth  = 32,
    parameter  int unsigned ImageHeight = 32,
    parameter  int unsigned MaxSteps    = 8,
    localparam int unsigned N  = ImageWidth * ImageHeight,
    localparam int unsigned AW = (MaxSteps > 1) ? $clog2(MaxSteps) : 1,
    localparam int unsigned LW = $clog2(MaxSteps + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          gene_we,
    input  logic [AW-1:0] gene_addr,
    input  logic [11:0]   gene_data,
    input  logic [LW-1:0] prog_len,
    input  logic          stop_on_stable,
    input  logic          start,
    input  logic          abort,
    input  logic [N-1:0]  image_in,
    output logic [N-1:0]  unit_img,
    output logic [8:0]    unit_el,
    output logic [2:0]    unit_op,
    input  logic [N-1:0]  unit_result,
    output logic          busy,
    output logic          done,
    output logic          result_valid,
    output logic [N-1:0]  result,
    output logic [LW-1:0] steps_run,
    output logic          stable
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  img_q, img_d;
    logic [LW-1:0] step_q, step_d;
    logic [LW-1:0] len_q, len_d;
    logic          sos_q, sos_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rv_q, rv_d;
    logic [N-1:0]  result_q, result_d;
    logic [LW-1:0] steps_run_q, steps_run_d;
    logic          stable_q, stable_d;

    logic [11:0]   gene_mem [MaxSteps];
    logic [AW-1:0] rd_idx;
    logic [LW-1:0] eff_len;
    logic          last_step;
    logic          converged;

    // Program store: not reset, writable only while idle.
    always_ff @(posedge clk) begin
        if (gene_we && !busy_q && (32'(gene_addr) < MaxSteps)) begin
            gene_mem[gene_addr] <= gene_data;
        end
    end

    assign rd_idx    = (state_q == RUN) ? AW'(step_q) : '0;
    assign eff_len   = (prog_len > LW'(MaxSteps)) ? LW'(MaxSteps) : prog_len;
    assign last_step = (step_q == len_q - LW'(1));
    assign converged = sos_q && (unit_result == img_q);

    assign unit_img             = img_q;
    assign {unit_el, unit_op}   = gene_mem[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            img_q       <= '0;
            step_q      <= '0;
            len_q       <= '0;
            sos_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rv_q        <= 1'b0;
            result_q    <= '0;
            steps_run_q <= '0;
            stable_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            img_q       <= img_d;
            step_q      <= step_d;
            len_q       <= len_d;
            sos_q       <= sos_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rv_q        <= rv_d;
            result_q    <= result_d;
            steps_run_q <= steps_run_d;
            stable_q    <= stable_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        img_d       = img_q;
        step_d      = step_q;
        len_d       = len_q;
        sos_d       = sos_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rv_d        = rv_q;
        result_d    = result_q;
        steps_run_d = steps_run_q;
        stable_d    = stable_q;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    img_d    = image_in;
                    step_d   = '0;
                    len_d    = eff_len;
                    sos_d    = stop_on_stable;
                    rv_d     = 1'b0;
                    stable_d = 1'b0;
                    // Empty program completes on the start edge itself.
                    if (eff_len == '0) begin
                        result_d    = image_in;
                        steps_run_d = '0;
                        done_d      = 1'b1;
                        rv_d        = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    img_d  = unit_result;
                    step_d = step_q + LW'(1);
                    if (last_step || converged) begin
                        result_d    = unit_result;
                        steps_run_d = step_q + LW'(1);
                        stable_d    = !last_step;
                        done_d      = 1'b1;
                        rv_d        = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign result_valid = rv_q;
    assign result       = result_q;
    assign steps_run    = steps_run_q;
    assign stable       = stable_q;

endmodule

// File: tb/tb_morph_program_sequencer.sv
// Bench for morph_program_sequencer: models the external morphologic unit and
// predicts each run's outcome by applying the stored genes to the image directly.
module tb_morph_program_sequencer;

    localparam int unsigned IW = 4;
    localparam int unsigned IH = 4;
    localparam int unsigned MS = 8;
    localparam int unsigned N  = IW * IH;
    localparam int unsigned AW = 3;
    localparam int unsigned LW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          gene_we = 1'b0;
    logic [AW-1:0] gene_addr = '0;
    logic [11:0]   gene_data = '0;
    logic [LW-1:0] prog_len = '0;
    logic          stop_on_stable = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [N-1:0]  image_in = '0;
    logic [N-1:0]  unit_img;
    logic [8:0]    unit_el;
    logic [2:0]    unit_op;
    logic [N-1:0]  unit_result;
    logic          busy;
    logic          done;
    logic          result_valid;
    logic [N-1:0]  result;
    logic [LW-1:0] steps_run;
    logic          stable;

    int            total = 0;
    int            passed = 0;
    logic [11:0]   mem_m [MS];
    logic [2:0]    ops_q [$];

    morph_program_sequencer #(.ImageWidth(IW), .ImageHeight(IH), .MaxSteps(MS)) dut (
        .clk(clk), .rst_n(rst_n), .gene_we(gene_we), .gene_addr(gene_addr),
        .gene_data(gene_data), .prog_len(prog_len), .stop_on_stable(stop_on_stable),
        .start(start), .abort(abort), .image_in(image_in), .unit_img(unit_img),
        .unit_el(unit_el), .unit_op(unit_op), .unit_result(unit_result), .busy(busy),
        .done(done), .result_valid(result_valid), .result(result),
        .steps_run(steps_run), .stable(stable)
    );

    always #5 clk = ~clk;

    // Morphologic unit: 0 bypass, 1 erode, 2 dilate, 3 invert, 4 rotate,
    // 5 mask with element, 6 xor with rotation, 7 bypass.
    function automatic logic [N-1:0] morph(input logic [N-1:0] img, input logic [8:0] el,
                                           input logic [2:0] op);
        logic [N-1:0] er, di, rot, msk;
        int rr, cc;
        logic all_b, any_b, px;
        for (int r = 0; r < int'(IH); r++) begin
            for (int c = 0; c < int'(IW); c++) begin
                all_b = 1'b1;
                any_b = 1'b0;
                for (int k = 0; k < 9; k++) begin
                    if (el[k]) begin
                        rr = r + k / 3 - 1;
                        cc = c + k % 3 - 1;
                        px = (rr >= 0 && rr < int'(IH) && cc >= 0 && cc < int'(IW))
                             ? img[rr * int'(IW) + cc] : 1'b0;
                        all_b = all_b & px;
                        any_b = any_b | px;
                    end
                end
                er[r * int'(IW) + c] = all_b;
                di[r * int'(IW) + c] = any_b;
            end
        end
        rot = {img[N-2:0], img[N-1]};
        msk = {img[15:9] & el[6:0], img[8:0] & el};
        case (op)
            3'd1:    return er;
            3'd2:    return di;
            3'd3:    return ~img;
            3'd4:    return rot;
            3'd5:    return msk;
            3'd6:    return img ^ rot;
            default: return img;
        endcase
    endfunction

    assign unit_result = morph(unit_img, unit_el, unit_op);

    // Expected outcome of one run from the gene list alone.
    task automatic model_run(input logic [N-1:0] img, input int pl, input bit sos,
                             output logic [N-1:0] res, output int steps, output bit stab);
        int len;
        logic [N-1:0] cur, nxt;
        len   = (pl > int'(MS)) ? int'(MS) : pl;
        cur   = img;
        res   = img;
        steps = 0;
        stab  = 1'b0;
        for (int s = 0; s < len; s++) begin
            nxt   = morph(cur, mem_m[s][11:3], mem_m[s][2:0]);
            steps = s + 1;
            res   = nxt;
            if (s != len - 1 && sos && nxt == cur) begin
                stab = 1'b1;
                break;
            end
            cur = nxt;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic write_gene(input int addr, input logic [11:0] data);
        gene_we   = 1'b1;
        gene_addr = AW'(addr);
        gene_data = data;
        @(posedge clk); #1;
        gene_we   = 1'b0;
        mem_m[addr] = data;
    endtask

    // Start a run, optionally abort at RUN cycle abort_at or attempt a write while busy.
    task automatic run(input logic [N-1:0] img, input int pl, input bit sos,
                       input int abort_at, input bit busy_wr, input string tag);
        logic [N-1:0] e_res;
        int e_steps, k, len;
        bit e_stab;
        model_run(img, pl, sos, e_res, e_steps, e_stab);
        len = (pl > int'(MS)) ? int'(MS) : pl;
        ops_q.delete();
        image_in       = img;
        prog_len       = LW'(pl);
        stop_on_stable = sos;
        start          = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ".busy_after_start"}, 64'(busy), 64'(len > 0));
        k = 0;
        while (k < 40 && !done) begin
            ops_q.push_back(unit_op);
            if (k == abort_at) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                check({tag, ".abort_busy"}, 64'(busy), 64'(0));
                check({tag, ".abort_done"}, 64'(done), 64'(0));
                check({tag, ".abort_rv"}, 64'(result_valid), 64'(0));
                return;
            end
            if (busy_wr && k == 1) begin
                gene_we   = 1'b1;
                gene_addr = '0;
                gene_data = ~mem_m[0];
            end
            @(posedge clk); #1;
            gene_we = 1'b0;
            k++;
        end
        check({tag, ".done"}, 64'(done), 64'(1));
        check({tag, ".latency"}, 64'(k), 64'(e_steps));
        check({tag, ".result"}, 64'(result), 64'(e_res));
        check({tag, ".steps_run"}, 64'(steps_run), 64'(e_steps));
        check({tag, ".stable"}, 64'(stable), 64'(e_stab));
        check({tag, ".rv"}, 64'(result_valid), 64'(1));
        check({tag, ".busy_end"}, 64'(busy), 64'(0));
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, 64'(done), 64'(0));
        check({tag, ".rv_hold"}, 64'(result_valid), 64'(1));
    endtask

    initial begin
        int seen_done;

        // Reset values
        #22 rst_n = 1'b1;
        #1;
        check("rst.busy", 64'(busy), 64'(0));
        check("rst.done", 64'(done), 64'(0));
        check("rst.rv", 64'(result_valid), 64'(0));
        check("rst.stable", 64'(stable), 64'(0));
        check("rst.steps_run", 64'(steps_run), 64'(0));
        check("rst.img", 64'(unit_img), 64'(0));
        @(posedge clk); #1;

        // Two-step erode/dilate on a single pixel
        write_gene(0, {9'h1FF, 3'b001});
        write_gene(1, {9'h1FF, 3'b010});
        run(16'h0020, 2, 1'b0, -1, 1'b0, "two_step");
        check("two_step.op0", 64'(ops_q[0]), 64'(3'b001));
        check("two_step.op1", 64'(ops_q[1]), 64'(3'b010));

        // Empty program
        run(16'hA5A5, 0, 1'b0, -1, 1'b0, "len0");
        check("len0.result", 64'(result), 64'(16'hA5A5));

        // Convergence on bypass genes
        for (int i = 0; i < 4; i++) write_gene(i, {9'(i * 37), 3'b000});
        run(16'h3C5A, 4, 1'b1, -1, 1'b0, "converge");
        check("converge.stable", 64'(stable), 64'(1));
        check("converge.steps", 64'(steps_run), 64'(1));

        // Over-long program clamps to MaxSteps; write while busy is dropped
        for (int i = 0; i < int'(MS); i++) write_gene(i, 12'($urandom));
        run(16'h1234, 12, 1'b0, -1, 1'b1, "clamp");
        check("clamp.steps", 64'(steps_run), 64'(MS));
        run(16'h8001, 12, 1'b0, -1, 1'b0, "clamp_reread");
        check("clamp_reread.op0", 64'(ops_q[0]), 64'(mem_m[0][2:0]));

        // Abort on second RUN cycle, then immediate restart
        run(16'h0F0F, 5, 1'b0, 1, 1'b0, "abort");
        run(16'h0FF0, 1, 1'b0, -1, 1'b0, "after_abort");

        // Start with abort in IDLE is dropped
        abort = 1'b1; start = 1'b1; prog_len = LW'(3);
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        check("abort_start.busy", 64'(busy), 64'(0));
        check("abort_start.done", 64'(done), 64'(0));
        check("abort_start.rv", 64'(result_valid), 64'(1));

        // Async reset mid-run
        image_in = 16'h5555; prog_len = LW'(5); stop_on_stable = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst.busy", 64'(busy), 64'(0));
        check("midrst.done", 64'(done), 64'(0));
        check("midrst.rv", 64'(result_valid), 64'(0));
        check("midrst.stable", 64'(stable), 64'(0));
        #3 rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) seen_done++;
        end
        check("midrst.no_done", 64'(seen_done), 64'(0));

        // Randomized programs
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < int'(MS); i++) begin
                logic [2:0] op;
                op = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 2) == 0) op = 3'b000;
                write_gene(i, {9'($urandom), op});
            end
            run(16'($urandom), int'($urandom_range(0, 12)), 1'($urandom), -1, 1'b0,
                $sformatf("rnd%0d", t));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
